// File: rtl/pwm_scheduler_if.sv
// rtl/pwm_scheduler_if.sv - host write and config RAM port bundle for pwm_scheduler
interface pwm_scheduler_if #(parameter int ADDR_W = 8);
  logic              hostWe;
  logic [ADDR_W-1:0] hostAddr;
  logic [15:0]       hostData;
  logic              hostReady;
  logic              ramWe;
  logic              ramRe;
  logic [ADDR_W-1:0] ramAddr;
  logic [15:0]       ramWdata;
  logic [15:0]       ramRdata;

  modport master (
    input  hostWe, hostAddr, hostData, ramRdata,
    output hostReady, ramWe, ramRe, ramAddr, ramWdata
  );

  modport slave (
    output hostWe, hostAddr, hostData, ramRdata,
    input  hostReady, ramWe, ramRe, ramAddr, ramWdata
  );
endinterface

// File: rtl/pwm_scheduler.sv
// rtl/pwm_scheduler.sv - per-period PWM on-time burst loader with atomic commit at counter wrap
// Optional on-time ceiling enabled by defining PWM_SCHED_CLAMP_EN.
module pwm_scheduler #(
  parameter int                NUM_CH       = 4,
  parameter int                ADDR_W       = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter logic [15:0]       WINDOW_START = 16'hEFFF
`ifdef PWM_SCHED_CLAMP_EN
  , parameter logic [15:0]     CLAMP_MAX    = 16'hEFFF
`endif
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic [15:0]            counter,
  input  logic                   ramSafe,
  pwm_scheduler_if.master        bus,
  output logic [16*NUM_CH-1:0]   onTime,
  output logic                   commit,
  output logic                   loadMiss
);

  localparam int IW = (NUM_CH < 2) ? 1 : $clog2(NUM_CH);

  typedef enum logic [3:0] {
    S_IDLE    = 4'b0001,
    S_READ    = 4'b0010,
    S_CAPTURE = 4'b0100,
    S_WAIT    = 4'b1000
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IW-1:0]       r_idx;
  logic [IW-1:0]       w_idx_nxt;
  logic                r_armed;
  logic                r_ramWe;
  logic                r_ramRe;
  logic [ADDR_W-1:0]   r_ramAddr;
  logic [15:0]         r_ramWdata;
  logic                r_hostReady;
  logic                r_commit;
  logic                r_miss;
  logic [16*NUM_CH-1:0] r_onTime;
  logic [15:0]         r_stage [NUM_CH];

  logic                w_host_req;
  logic                w_in_win;
  logic                w_start;
  logic                w_grant;
  logic                w_commit;
  logic                w_miss;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [15:0]         w_word;

  // A request already answered this cycle is masked so a held hostWe is not written twice.
  assign w_host_req = bus.hostWe && !r_hostReady;
  assign w_in_win   = (counter >= WINDOW_START);
  assign w_rd_addr  = BASE_ADDR + ADDR_W'(w_idx_nxt);

`ifdef PWM_SCHED_CLAMP_EN
  assign w_word = (bus.ramRdata > CLAMP_MAX) ? CLAMP_MAX : bus.ramRdata;
`else
  assign w_word = bus.ramRdata;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_start     = 1'b0;
    w_commit    = 1'b0;
    w_miss      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_in_win && ramSafe && r_armed && !w_host_req) begin
          w_start     = 1'b1;
          w_state_nxt = S_READ;
          w_idx_nxt   = '0;
        end
      end
      S_READ: begin
        if (!w_in_win) begin
          w_miss      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_idx == IW'(NUM_CH - 1)) begin
          w_state_nxt = S_CAPTURE;
        end else begin
          w_idx_nxt = r_idx + IW'(1);
        end
      end
      S_CAPTURE: begin
        if (!w_in_win) begin
          w_miss      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (counter == 16'hFFFF) begin
          w_commit    = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (!w_in_win) begin
          w_miss      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_grant = w_host_req && ((r_state == S_IDLE) || (r_state == S_WAIT)) && !w_start;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_armed <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_start)
        r_armed <= 1'b0;
      else if (counter == 16'h0000)
        r_armed <= 1'b1;
    end
  end

  // RAM port is registered; a read burst and a host grant are mutually exclusive by construction.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_ramWe     <= 1'b0;
      r_ramRe     <= 1'b0;
      r_ramAddr   <= '0;
      r_ramWdata  <= '0;
      r_hostReady <= 1'b0;
      r_commit    <= 1'b0;
      r_miss      <= 1'b0;
    end else begin
      r_ramRe     <= (w_state_nxt == S_READ);
      r_ramWe     <= w_grant;
      r_hostReady <= w_grant;
      r_commit    <= w_commit;
      r_miss      <= w_miss;
      if (w_state_nxt == S_READ) begin
        r_ramAddr <= w_rd_addr;
      end else if (w_grant) begin
        r_ramAddr  <= bus.hostAddr;
        r_ramWdata <= bus.hostData;
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_onTime <= '0;
      for (int i = 0; i < NUM_CH; i++) r_stage[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (((r_state == S_READ) && (r_idx == IW'(i + 1))) ||
            ((r_state == S_CAPTURE) && (i == NUM_CH - 1)))
          r_stage[i] <= w_word;
        if (w_commit)
          r_onTime[16*i +: 16] <= r_stage[i];
      end
    end
  end

  assign bus.ramWe     = r_ramWe;
  assign bus.ramRe     = r_ramRe;
  assign bus.ramAddr   = r_ramAddr;
  assign bus.ramWdata  = r_ramWdata;
  assign bus.hostReady = r_hostReady;
  assign onTime        = r_onTime;
  assign commit        = r_commit;
  assign loadMiss      = r_miss;

endmodule

// File: tb/tb_pwm_scheduler.sv
// tb/tb_pwm_scheduler.sv - self-checking bench for pwm_scheduler with a load-schedule model
module tb_pwm_scheduler;
  localparam int NUM_CH = 4;
  localparam int ADDR_W = 8;
  localparam logic [15:0] WS = 16'hEFFF;
`ifdef PWM_SCHED_CLAMP_EN
  localparam logic [15:0] CL2 = 16'hEFFF;
`else
  localparam logic [15:0] CL2 = 16'hFFFF;
`endif

  logic clock = 1'b0;
  logic resetN = 1'b0;
  logic [15:0] counter = 16'h0000;
  logic ramSafe = 1'b1;
  logic [16*NUM_CH-1:0] onTime;
  logic commit, loadMiss;

  pwm_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

  pwm_scheduler #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .resetN(resetN), .counter(counter), .ramSafe(ramSafe),
    .bus(bus), .onTime(onTime), .commit(commit), .loadMiss(loadMiss)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] clampf(input logic [15:0] w);
`ifdef PWM_SCHED_CLAMP_EN
    return (w > 16'hEFFF) ? 16'hEFFF : w;
`else
    return w;
`endif
  endfunction

  // Model: a load is a timeline measured in cycles since its start, not a state machine.
  logic [15:0] ram [256];
  int          m_k = 0;
  bit          m_armed = 1'b1;
  logic [15:0] m_stage [NUM_CH];
  logic [15:0] m_on [NUM_CH] = '{default: 16'h0};
  logic        e_ramRe = 0, e_ramWe = 0, e_hostReady = 0, e_commit = 0, e_miss = 0;
  logic [7:0]  e_ramAddr = 0;
  logic [15:0] e_ramWdata = 0;
  logic [15:0] prev_ctr = 0;

  always @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      m_k = 0; m_armed = 1'b1;
      e_ramRe = 0; e_ramWe = 0; e_hostReady = 0; e_commit = 0; e_miss = 0;
      for (int i = 0; i < NUM_CH; i++) m_on[i] = 16'h0;
    end else begin
      bit req, start, grant;
      prev_ctr = counter;
      req   = bus.hostWe && !e_hostReady;
      start = (m_k == 0) && (counter >= WS) && ramSafe && m_armed && !req;
      grant = req && ((m_k == 0) || (m_k >= NUM_CH + 2)) && !start;
      if (m_k == 1)
        for (int i = 0; i < NUM_CH; i++) m_stage[i] = clampf(ram[i]);
      e_ramRe = 0; e_ramWe = 0; e_hostReady = 0; e_commit = 0; e_miss = 0;
      if (grant) begin
        e_ramWe = 1; e_hostReady = 1; e_ramAddr = bus.hostAddr; e_ramWdata = bus.hostData;
      end
      if (counter == 16'h0000) m_armed = 1'b1;
      if (start) begin
        m_armed = 1'b0; m_k = 1;
      end else if (m_k > 0) begin
        if (m_k >= NUM_CH + 2 && counter == 16'hFFFF) begin
          for (int i = 0; i < NUM_CH; i++) m_on[i] = m_stage[i];
          e_commit = 1; m_k = 0;
        end else if (counter < WS) begin
          e_miss = 1; m_k = 0;
        end else if (m_k < NUM_CH + 2) begin
          m_k++;
        end
      end
      if (m_k >= 1 && m_k <= NUM_CH) begin
        e_ramRe = 1; e_ramAddr = 8'(m_k - 1);
      end
    end
    if (bus.ramRe) bus.ramRdata <= ram[bus.ramAddr];
    if (bus.ramWe) ram[bus.ramAddr] = bus.ramWdata;
  end

  int n_commit, n_miss, n_re;
  bit seen_re;
  logic [15:0] first_re_ctr, last_ready_ctr;

  task automatic clear_obs();
    n_commit = 0; n_miss = 0; n_re = 0; seen_re = 0;
    first_re_ctr = 16'h0; last_ready_ctr = 16'h0;
  endtask

  always @(negedge clock) begin
    if (resetN) begin
      logic [16*NUM_CH-1:0] e_on;
      for (int i = 0; i < NUM_CH; i++) e_on[16*i +: 16] = m_on[i];
      chk("ramRe", bus.ramRe, e_ramRe);
      chk("ramWe", bus.ramWe, e_ramWe);
      chk("hostReady", bus.hostReady, e_hostReady);
      chk("commit", commit, e_commit);
      chk("loadMiss", loadMiss, e_miss);
      chk("onTime", onTime, e_on);
      if (e_ramRe || e_ramWe) chk("ramAddr", bus.ramAddr, e_ramAddr);
      if (e_ramWe) chk("ramWdata", bus.ramWdata, e_ramWdata);
      if (commit) n_commit++;
      if (loadMiss) n_miss++;
      if (bus.ramRe) begin
        n_re++;
        if (!seen_re) begin seen_re = 1; first_re_ctr = prev_ctr; end
      end
      if (bus.hostReady) last_ready_ctr = prev_ctr;
    end
  end

  task automatic tick(input logic [15:0] c);
    counter = c;
    @(posedge clock);
    #1;
    if (bus.hostReady) bus.hostWe = 1'b0;
  endtask

  task automatic sweep(input int a, input int b);
    for (int c = a; c <= b; c++) tick(16'(c));
  endtask

  task automatic period();
    sweep(16'hEFF0, 16'hFFFF);
    sweep(0, 4);
  endtask

  initial begin
    bus.hostWe = 0; bus.hostAddr = 0; bus.hostData = 0;
    for (int i = 0; i < 256; i++) ram[i] = 16'h0;
    ram[0] = 16'h1000; ram[1] = 16'h2000; ram[2] = 16'h3000; ram[3] = 16'h4000;
    clear_obs();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_onTime", onTime, 0);
    chk("rst_ramRe", bus.ramRe, 0);
    chk("rst_hostReady", bus.hostReady, 0);
    chk("rst_commit", commit, 0);
    resetN = 1;

    clear_obs(); period();
    chk("p1_onTime", onTime, 64'h4000_3000_2000_1000);
    chk("p1_commits", n_commit, 1);
    chk("p1_first_re", first_re_ctr, 16'hEFFF);
    chk("p1_re_count", n_re, NUM_CH);

    clear_obs();
    sweep(16'hEFF0, 16'hEFFE);
    bus.hostWe = 1; bus.hostAddr = 8'h10; bus.hostData = 16'hABCD;
    tick(16'hEFFF);
    tick(16'hF000);
    bus.hostWe = 1; bus.hostAddr = 8'h11; bus.hostData = 16'h5555;
    sweep(16'hF001, 16'hFFFF); sweep(0, 4);
    chk("p2_first_re", first_re_ctr, 16'hF000);
    chk("p2_ready_in_wait", last_ready_ctr, 16'hF006);
    chk("p2_ram10", ram[8'h10], 16'hABCD);
    chk("p2_ram11", ram[8'h11], 16'h5555);
    chk("p2_commits", n_commit, 1);

    clear_obs(); ramSafe = 0; period();
    chk("p3_re_count", n_re, 0);
    chk("p3_commits", n_commit, 0);
    chk("p3_onTime", onTime, 64'h4000_3000_2000_1000);

    clear_obs(); ramSafe = 1; ram[2] = 16'hFFFF; period();
    chk("p4_ch2_clamp", onTime[47:32], CL2);
    chk("p4_commits", n_commit, 1);

    clear_obs(); ram[0] = 16'h0111;
    sweep(16'hEFF0, 16'hFFFE); sweep(0, 5);
    chk("p5_miss", n_miss, 1);
    chk("p5_commits", n_commit, 0);
    chk("p5_onTime", onTime, {16'h4000, CL2, 16'h2000, 16'h1000});
    clear_obs(); period();
    chk("p5b_onTime", onTime, {16'h4000, CL2, 16'h2000, 16'h0111});

    clear_obs(); ramSafe = 0;
    sweep(16'hEFF0, 16'hFFFE);
    ramSafe = 1; tick(16'hFFFF); sweep(0, 4);
    chk("p6_miss", n_miss, 1);
    chk("p6_commits", n_commit, 0);
    chk("p6_re_count", n_re, 1);

    clear_obs();
    sweep(16'hEFF0, 16'hF001);
    resetN = 0;
    #1;
    chk("mid_rst_ramRe", bus.ramRe, 0);
    chk("mid_rst_onTime", onTime, 0);
    chk("mid_rst_hostReady", bus.hostReady, 0);
    #1 resetN = 1;
    clear_obs();
    sweep(16'hF002, 16'hFFFF); sweep(0, 4);
    chk("p7_commits", n_commit, 1);
    chk("p7_onTime", onTime, {16'h4000, CL2, 16'h2000, 16'h0111});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pwm_scheduler.md
Name: pwm_scheduler

Overview:
Loads per-channel PWM on-times from the shared configuration RAM once per PWM period and commits them atomically at the period wrap. Shares the single RAM port between its own burst reads and host (SPI-side) writes. Sits between the config RAM, the host register interface and the PWM output stages. All channels are driven by one free-running 16-bit period counter.

Parameters:
NUM_CH, 4, number of PWM channels (1..16)
ADDR_W, 8, RAM address width
BASE_ADDR, 8'h00, RAM address of channel 0 on-time; channel i at BASE_ADDR+i
WINDOW_START, 16'hEFFF, counter value at or above which loading is allowed
CLAMP_MAX, 16'hEFFF, on-time ceiling (used only with PWM_SCHED_CLAMP_EN)

Ports:
clock  in  1  system clock, all logic on rising edge
resetN  in  1  asynchronous, active-low reset
counter  in  16  free-running PWM period counter, wraps 16'hFFFF->0
ramSafe  in  1  high when RAM contents are consistent (host not mid-update)
hostWe  in  1  host write request, held until hostReady
hostAddr  in  ADDR_W  host write address
hostData  in  16  host write data
hostReady  out  1  one-cycle pulse: host write performed this cycle
ramWe  out  1  RAM write enable
ramRe  out  1  RAM read enable
ramAddr  out  ADDR_W  RAM address
ramWdata  out  16  RAM write data
ramRdata  in  16  RAM read data, valid the cycle after ramRe (sync RAM)
onTime  out  16*NUM_CH  active on-times, channel i at [16i+15:16i]
commit  out  1  one-cycle pulse when onTime updates
loadMiss  out  1  one-cycle pulse when a load is aborted

Behaviour:
- Reset (resetN low, async): all outputs 0, onTime all 0, staging regs 0, state IDLE, armed=1.
- RAM port outputs are registered; ramWe and ramRe are never high together.
- Host write: granted in any cycle the state is IDLE or WAIT and no load starts that cycle. Grant drives ramWe=1, ramAddr=hostAddr, ramWdata=hostData, hostReady=1 in the same cycle. At most one write per cycle. hostWe during READ/CAPTURE stalls (hostReady=0) with no write.
- armed: set when counter==16'h0000; cleared on entering READ.
- FSM (one-hot):
  IDLE: if counter>=WINDOW_START && ramSafe && armed && !hostWe -> READ (idx=0); else stay. hostWe has priority in the start cycle; start re-evaluated next cycle.
  READ: ramRe=1, ramAddr=BASE_ADDR+idx, idx++ each cycle; data for idx-1 captured into staging[idx-1]. After idx=NUM_CH-1 is issued -> CAPTURE.
  CAPTURE: capture last word into staging[NUM_CH-1] -> WAIT.
  WAIT: when counter==16'hFFFF: onTime<=staging (all channels same cycle), commit=1 -> IDLE.
- Burst: NUM_CH+1 cycles from READ entry to WAIT entry; commit lands on the clock edge with counter==16'hFFFF, so new onTime is valid for counter==0.
- Abort: if counter<WINDOW_START (counter wrapped past 16'hFFFF) in READ, CAPTURE or WAIT before commit, discard staging, keep old onTime, pulse loadMiss, -> IDLE. armed stays 0 until next counter==0.
- ramSafe falling during READ does not abort; sampled only in IDLE.
- counter==16'hFFFF in the same cycle a load would start: load starts; the commit then misses and aborts as above.
- Address arithmetic wraps modulo 2^ADDR_W.

Optional Feature:
PWM_SCHED_CLAMP_EN: when defined, each captured word > CLAMP_MAX is stored as CLAMP_MAX, guaranteeing off-time every period. When undefined, words are stored unmodified and CLAMP_MAX is unused.

Test Plan:
- Reset: resetN low mid-burst -> all outputs 0 immediately; after release, first commit occurs at the first counter==16'hFFFF after a window load.
- RAM[0..3]=16'h1000,2000,3000,4000, ramSafe=1, counter sweep -> ramRe at counter 16'hEFFF..+3, commit at 16'hFFFF, onTime=4000_3000_2000_1000, exactly one commit per period.
- hostWe held at counter=16'hEFFF -> write first (hostReady pulse, ramWe=1), READ starts next cycle; hostWe raised during READ -> hostReady waits until WAIT.
- ramSafe=0 through whole window -> no ramRe, no commit, onTime unchanged; ramSafe=1 next period -> normal load.
- Force counter 16'hFFFE->16'h0000 jump during WAIT -> loadMiss pulse, onTime unchanged, no reload until counter passes 0 and reaches window again.
- PWM_SCHED_CLAMP_EN defined, RAM[2]=16'hFFFF -> onTime channel 2 = 16'hEFFF; undefined -> 16'hFFFF.
